// File: rtl/intersection_phase_scheduler.sv
`default_nettype none
// intersection_phase_scheduler: NS/EW/pedestrian right-of-way sequencer with Moore lamp decode.
// Optional build macro TLC_NIGHT_FLASH_EN adds night_mode input and a flashing-yellow FLASH state.
module intersection_phase_scheduler #(
    parameter int CLK_FREQUENCY = 27_000_000,
    parameter int GREEN_MS      = 7000,
    parameter int YELLOW_MS     = 3000,
    parameter int ALL_RED_MS    = 1000,
    parameter int WALK_MS       = 5000
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       car_ew,
    input  logic       ped_req,
`ifdef TLC_NIGHT_FLASH_EN
    input  logic       night_mode,
`endif
    output logic       ped_ack,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       walk,
    output logic [2:0] phase
);

    localparam int TICKS_PER_MS = CLK_FREQUENCY / 1000;
    localparam int PRE_W        = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam int FLASH_MS     = 500;
    localparam int MAX_A        = (GREEN_MS > YELLOW_MS) ? GREEN_MS : YELLOW_MS;
    localparam int MAX_B        = (ALL_RED_MS > WALK_MS) ? ALL_RED_MS : WALK_MS;
    localparam int MAX_C        = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_MS       = (MAX_C > FLASH_MS) ? MAX_C : FLASH_MS;
    localparam int MS_W         = $clog2(MAX_MS + 1);

    typedef enum logic [2:0] {
        S_INIT      = 3'd0,
        S_NS_GREEN  = 3'd1,
        S_NS_YELLOW = 3'd2,
        S_ALLRED_A  = 3'd3,
        S_EW_GREEN  = 3'd4,
        S_EW_YELLOW = 3'd5,
        S_ALLRED_B  = 3'd6,
        S_WALK      = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [PRE_W-1:0]  presc_q;
    logic [MS_W-1:0]   ms_q;
    logic [MS_W-1:0]   dur_m1;
    logic              ew_pend_q, ew_pend_d;
    logic              ped_pend_q, ped_pend_d;
    logic              dir_next_q, dir_next_d;
    logic              ped_ack_q;
    logic              flash_q, flash_d;
    logic              flash_on_q, flash_on_d;
    logic              done;
    logic              tmr_clr;
    logic              enter_ew;
    logic              enter_walk;

    always_comb begin
        dur_m1 = MS_W'(ALL_RED_MS - 1);
        if (flash_q) begin
            dur_m1 = MS_W'(FLASH_MS - 1);
        end else begin
            case (state_q)
                S_NS_GREEN, S_EW_GREEN:   dur_m1 = MS_W'(GREEN_MS - 1);
                S_NS_YELLOW, S_EW_YELLOW: dur_m1 = MS_W'(YELLOW_MS - 1);
                S_WALK:                   dur_m1 = MS_W'(WALK_MS - 1);
                default:                  dur_m1 = MS_W'(ALL_RED_MS - 1);
            endcase
        end
    end

    assign done = (presc_q == PRE_W'(TICKS_PER_MS - 1)) && (ms_q == dur_m1);

    // Next-state: every transition (including the NS_GREEN restart) happens on done.
    always_comb begin
        state_d    = state_q;
        dir_next_d = dir_next_q;
        flash_d    = flash_q;
        flash_on_d = flash_on_q;
        if (flash_q) begin
`ifdef TLC_NIGHT_FLASH_EN
            if (done) begin
                if (!night_mode) begin
                    flash_d    = 1'b0;
                    flash_on_d = 1'b0;
                    state_d    = S_INIT;
                end else begin
                    flash_on_d = ~flash_on_q;
                end
            end
`else
            flash_d    = 1'b0;
            flash_on_d = 1'b0;
            state_d    = S_INIT;
`endif
        end else begin
            case (state_q)
                S_INIT:      if (done) state_d = S_NS_GREEN;
                S_NS_GREEN:  if (done && (ew_pend_q || ped_pend_q)) state_d = S_NS_YELLOW;
                S_NS_YELLOW: if (done) state_d = S_ALLRED_A;
                S_ALLRED_A: begin
                    if (done) begin
`ifdef TLC_NIGHT_FLASH_EN
                        if (night_mode) begin
                            state_d    = S_INIT;
                            flash_d    = 1'b1;
                            flash_on_d = 1'b1;
                        end else
`endif
                        if (ped_pend_q) begin
                            state_d    = S_WALK;
                            dir_next_d = 1'b1;
                        end else begin
                            state_d    = S_EW_GREEN;
                        end
                    end
                end
                S_EW_GREEN:  if (done) state_d = S_EW_YELLOW;
                S_EW_YELLOW: if (done) state_d = S_ALLRED_B;
                S_ALLRED_B: begin
                    if (done) begin
`ifdef TLC_NIGHT_FLASH_EN
                        if (night_mode) begin
                            state_d    = S_INIT;
                            flash_d    = 1'b1;
                            flash_on_d = 1'b1;
                        end else
`endif
                        if (ped_pend_q) begin
                            state_d    = S_WALK;
                            dir_next_d = 1'b0;
                        end else begin
                            state_d    = S_NS_GREEN;
                        end
                    end
                end
                S_WALK:      if (done) state_d = dir_next_q ? S_EW_GREEN : S_NS_GREEN;
                default:     state_d = S_INIT;
            endcase
        end
    end

    assign tmr_clr    = done || (state_d != state_q) || (flash_d != flash_q);
    assign enter_ew   = (state_d == S_EW_GREEN) && (state_q != S_EW_GREEN);
    assign enter_walk = (state_d == S_WALK) && (state_q != S_WALK);

    // Clear beats set; pedestrian requests seen during WALK are discarded.
    assign ew_pend_d  = enter_ew ? 1'b0 : (ew_pend_q | car_ew);
    assign ped_pend_d = enter_walk ? 1'b0 : (ped_pend_q | (ped_req & (state_q != S_WALK)));

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            presc_q    <= '0;
            ms_q       <= '0;
            ew_pend_q  <= 1'b0;
            ped_pend_q <= 1'b0;
            dir_next_q <= 1'b0;
            ped_ack_q  <= 1'b0;
            flash_q    <= 1'b0;
            flash_on_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ew_pend_q  <= ew_pend_d;
            ped_pend_q <= ped_pend_d;
            dir_next_q <= dir_next_d;
            ped_ack_q  <= enter_walk;
            flash_q    <= flash_d;
            flash_on_q <= flash_on_d;
            if (tmr_clr) begin
                presc_q <= '0;
                ms_q    <= '0;
            end else if (presc_q == PRE_W'(TICKS_PER_MS - 1)) begin
                presc_q <= '0;
                ms_q    <= ms_q + 1'b1;
            end else begin
                presc_q <= presc_q + 1'b1;
            end
        end
    end

    always_comb begin
        ns_red    = 1'b1;
        ns_yellow = 1'b0;
        ns_green  = 1'b0;
        ew_red    = 1'b1;
        ew_yellow = 1'b0;
        ew_green  = 1'b0;
        walk      = 1'b0;
        if (flash_q) begin
            ns_red    = 1'b0;
            ns_yellow = flash_on_q;
            ew_red    = flash_on_q;
        end else begin
            case (state_q)
                S_NS_GREEN:  begin ns_red = 1'b0; ns_green  = 1'b1; end
                S_NS_YELLOW: begin ns_red = 1'b0; ns_yellow = 1'b1; end
                S_EW_GREEN:  begin ew_red = 1'b0; ew_green  = 1'b1; end
                S_EW_YELLOW: begin ew_red = 1'b0; ew_yellow = 1'b1; end
                S_WALK:      walk = 1'b1;
                default:     ;
            endcase
        end
    end

    assign ped_ack = ped_ack_q;
    assign phase   = state_q;

endmodule
`default_nettype wire
